// File: rtl/q16_pkg.sv
// Shared Q16.16 constants and helpers for the divider slice.
//   Q16_ONE / Q16_MAX / Q16_MIN : fixed-point landmarks
//   FRAC_BITS                   : fractional bit count
//   sat_q16()                   : Q32.32 product -> saturated Q16.16
package q16_pkg;

    localparam logic [31:0] Q16_ONE   = 32'h0001_0000;
    localparam logic [31:0] Q16_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] Q16_MIN   = 32'h8000_0000;
    localparam int          FRAC_BITS = 16;

    // Arithmetic shift floors toward -inf; clamp anything outside int32.
    function automatic logic [31:0] sat_q16(input logic signed [63:0] p);
        logic signed [63:0] q;
        q = p >>> FRAC_BITS;
        if (q > 64'sh0000_0000_7FFF_FFFF) return Q16_MAX;
        if (q < 64'shFFFF_FFFF_8000_0000) return Q16_MIN;
        return q[31:0];
    endfunction

endpackage

// File: rtl/q16_divide_stage_if.sv
// Request/response bus of the Q16.16 divider.
//   in_valid/in_ready/num_in/den_in      : dividend/divisor request
//   out_valid/out_ready/quot_out/div0_out: quotient response
// master = upstream/downstream side, slave = the divider.
interface q16_divide_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num_in;
    logic [31:0] den_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quot_out;
    logic        div0_out;

    modport master (output in_valid, num_in, den_in, out_ready,
                    input  in_ready, out_valid, quot_out, div0_out);
    modport slave  (input  in_valid, num_in, den_in, out_ready,
                    output in_ready, out_valid, quot_out, div0_out);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n       : clock, synchronous active-low reset
//   wr_en, wr_data   : push (accepted when not full, or full with a pop)
//   rd_en, rd_data   : pop; rd_data shows the head while !empty
//   full, empty, count
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/q16_divide_stage.sv
// Signed Q16.16 divider built around an external reciprocal wrapper.
//   clk, rst_n      : clock, synchronous active-low reset (shared with wrapper)
//   io (slave)      : in_* request bus, out_* quotient bus
//   recip_valid_in  : request strobe to wrapper
//   recip_x         : divisor to wrapper
//   recip_y         : 1/den from wrapper
//   recip_valid_out : wrapper result strobe
//   err_orphan      : sticky, a wrapper result arrived with no numerator queued
// The wrapper cannot stall, so a credit per output slot is taken at accept
// and returned at output pop; every issued request has a landing place.
module q16_divide_stage
    import q16_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int RECIP_LAT = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    q16_divide_stage_if.slave         io,
    output logic                      recip_valid_in,
    output logic [31:0]               recip_x,
    input  logic [31:0]               recip_y,
    input  logic                      recip_valid_out,
    output logic                      err_orphan
);
    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RECIP_LAT < 1) begin : g_bad_param
        $error("q16_divide_stage: DEPTH must be a power of two >= 2, RECIP_LAT >= 1");
    end

    logic [CW-1:0]     credits;
    logic              live;
    logic              accept, pop, ret_ok;

    logic [32:0]       nf_rd;
    logic              nf_full, nf_empty;
    logic [CW-1:0]     nf_count;
    logic [32:0]       of_rd;
    logic              of_full, of_empty;
    logic [CW-1:0]     of_count;

    logic              prod_vld, prod_div0, prod_neg;
    logic signed [63:0] prod;
    logic [31:0]       q_res;

    // live holds in_ready low during reset and releases it the cycle after.
    assign io.in_ready = live & (credits != '0);
    assign accept      = io.in_valid & io.in_ready;
    assign pop         = io.out_valid & io.out_ready;
    assign ret_ok      = recip_valid_out & ~nf_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live           <= 1'b0;
            credits        <= CW'(DEPTH);
            recip_valid_in <= 1'b0;
            recip_x        <= '0;
        end else begin
            live           <= 1'b1;
            recip_valid_in <= accept;
            if (accept) recip_x <= io.den_in;
            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: ;
            endcase
        end
    end

    // Numerator and its div-by-zero tag wait here for the reciprocal.
    sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_num_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data ({io.num_in, io.den_in == 32'd0}),
        .rd_en   (recip_valid_out),
        .rd_data (nf_rd),
        .full    (nf_full),
        .empty   (nf_empty),
        .count   (nf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_vld   <= 1'b0;
            prod       <= '0;
            prod_div0  <= 1'b0;
            prod_neg   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            prod_vld <= ret_ok;
            if (ret_ok) begin
                // Sign-extended 64x64 product, low half equals the signed Q32.32 result.
                prod      <= {{32{nf_rd[32]}}, nf_rd[32:1]} * {{32{recip_y[31]}}, recip_y};
                prod_div0 <= nf_rd[0];
                prod_neg  <= nf_rd[32];
            end
            if (recip_valid_out && nf_empty) err_orphan <= 1'b1;
        end
    end

    // Divide by zero ignores the (meaningless) reciprocal and pins to the rail.
    always_comb begin
        q_res = sat_q16(prod);
        if (prod_div0) q_res = prod_neg ? Q16_MIN : Q16_MAX;
    end

    sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (prod_vld),
        .wr_data ({q_res, prod_div0}),
        .rd_en   (pop),
        .rd_data (of_rd),
        .full    (of_full),
        .empty   (of_empty),
        .count   (of_count)
    );

    assign io.out_valid = ~of_empty;
    assign io.quot_out  = of_empty ? '0 : of_rd[32:1];
    assign io.div0_out  = ~of_empty & of_rd[0];

    // Every outstanding credit sits in exactly one place: num FIFO, product
    // register or output FIFO. Orphans break that bookkeeping by definition.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(prod_vld && of_full && !pop));
            assert (!(accept && nf_full));
            if (!err_orphan)
                assert (int'(credits) + int'(nf_count) + int'(prod_vld) + int'(of_count) == DEPTH);
        end
    end
endmodule

// File: doc/q16_divide_stage.md
Name: q16_divide_stage

Overview:
Downstream consumer of the Q16.16 reciprocal wrapper. It turns the wrapper into a full signed Q16.16 divider (quotient = num / den) with valid/ready flow control on both sides.
- Accepts (num, den) pairs and issues den to the wrapper.
- Holds each numerator in an alignment FIFO while the reciprocal is in flight.
- Multiplies numerator by the returned reciprocal, saturates, and buffers quotients in an output FIFO.
- The wrapper has no backpressure, so a credit counter guarantees every issued request has a guaranteed output slot.

Parameters:
DEPTH, 8, entries in both the numerator FIFO and the output FIFO; also the maximum number of requests in flight (power of two, >= 2).
RECIP_LAT, 6, cycles from wrapper valid_in to wrapper valid_out (informational; the design must not depend on it for correctness).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset; synchronous, active-low.
in_valid  in  1  upstream request valid.
in_ready  out  1  block can accept a request.
num_in  in  32  signed Q16.16 dividend.
den_in  in  32  signed Q16.16 divisor.
recip_valid_in  out  1  to wrapper valid_in.
recip_x  out  32  to wrapper x_in (registered den).
recip_y  in  32  from wrapper y_out, signed Q16.16 1/den.
recip_valid_out  in  1  from wrapper valid_out.
out_valid  out  1  quotient available.
out_ready  in  1  downstream accepts quotient.
quot_out  out  32  signed Q16.16 quotient.
div0_out  out  1  quotient came from den == 0.
err_orphan  out  1  sticky: a wrapper result arrived with the numerator FIFO empty.

Behaviour:
- Reset: when rst_n is low at a clock edge, the following are cleared:
  - in_ready=0 during reset, 1 on the first cycle after.
  - recip_valid_in=0, recip_x=0.
  - out_valid=0, quot_out=0, div0_out=0, err_orphan=0.
  - Both FIFOs emptied; credits=DEPTH; product stage invalid.
  - The wrapper shares rst_n, so its pipeline is flushed too. Reset mid-operation discards all in-flight work, with no output after release.
- Credits: in_ready = (credits != 0).
  - Accept (in_valid & in_ready) decrements credits; output pop (out_valid & out_ready) increments them.
  - On a simultaneous accept and pop, credits are unchanged.
  - credits never exceeds DEPTH and never goes below 0.
- Issue (cycle t = accept):
  - At edge t: recip_x<=den_in and recip_valid_in<=1 for exactly one cycle (t+1).
  - Also at edge t: push {num_in, den_in==0} into the numerator FIFO.
  - Back-to-back accepts give back-to-back issues.
- Return (recip_valid_out=1):
  - Pop the numerator FIFO head; register prod = num * recip_y as a full signed 64-bit product (Q32.32), together with the div0 flag.
  - If the FIFO is empty: drop the result and set err_orphan (sticky until reset).
- Scale/saturate (combinational from the product register):
  - q = prod >>> 16 (arithmetic shift, truncation toward -inf).
  - If q > 0x7FFFFFFF, the result is 0x7FFFFFFF; if q < -0x80000000, it is 0x80000000.
  - If div0=1, the result is forced: num >= 0 gives 0x7FFFFFFF, num < 0 gives 0x80000000. div0_out=1.
  - The product register writes the output FIFO one cycle after capture. Credits guarantee the output FIFO is never full on a write; a full-FIFO write is an assertion failure.
- Output FIFO: first-word-fall-through.
  - out_valid = !empty; quot_out and div0_out show the head.
  - Head is stable while out_valid & !out_ready.
  - Simultaneous write and pop in the same cycle is legal, including when empty+1 or full.
- Latency:
  - accept at edge t → out_valid high in cycle t+RECIP_LAT+3 (9 with defaults).
  - Throughput is 1 per cycle with out_ready held at 1.
  - Order is strictly preserved.
- Accuracy: quotient within ±2 LSB of the ideal truncated value whenever the reciprocal is in range (inherits the wrapper's error).

Decomposition:
- Shared package q16_pkg holds:
  - Q16_ONE=32'h0001_0000, Q16_MAX=32'h7FFF_FFFF, Q16_MIN=32'h8000_0000, FRAC_BITS=16.
  - A saturate-from-64-bit function.
- One sub-module, sync_fifo (parameter WIDTH, DEPTH; FWFT; sync active-low reset; full/empty/count), instantiated twice: numerator FIFO WIDTH=33, output FIFO WIDTH=33.
- The wrapper is instantiated by the parent, not inside this block.

Test Plan:
- Basic: num=0x000A0000, den=0x00020000, out_ready=1 → quot_out=0x00050000 ±2 LSB, div0_out=0, out_valid 9 cycles after accept.
- Sign: num=0xFFFD0000 (-3.0), den=0x00018000 (1.5) → quot_out=0xFFFE0000 ±2 LSB; and den negated → 0x00020000 ±2.
- Divide by zero: num=0x00050000, den=0 → 0x7FFFFFFF, div0_out=1; num=0xFFFB0000, den=0 → 0x80000000, div0_out=1.
- Saturation: num=0x7FFF0000, den=0x00000100 → quot_out=0x7FFFFFFF, div0_out=0.
- Backpressure and credits:
  - Stimulus: out_ready=0, offer 12 consecutive requests.
  - Required: exactly 8 accepted, then in_ready=0.
  - Then raise out_ready → 8 quotients drain in order, in_ready returns, remaining 4 complete.
  - No err_orphan, no FIFO overflow.
- Reset mid-flight: accept 3 requests, assert rst_n=0 for 1 cycle at accept+4 → no out_valid for 20 cycles after release, credits=8 (8 new accepts possible), err_orphan=0.
